// File: rtl/uart_rx_pkt_ctrl.sv
// Purpose: frames UART bytes (SOF, LEN, payload, CHK), buffers the payload, releases it only after the checksum passes.
// Latency: out_valid rises the cycle after the CHK byte event; one payload byte per accepted cycle.
// Backpressure: out_data/out_valid hold while out_ready=0; the receiver is held in reset (rx_en=0) for the whole drain.
// Ports: tick (clock), reset (async active-low), rx_data/rx_done from the UART receiver, rx_en to its reset;
//        out_data/out_valid/out_ready/out_last payload stream; pkt_err pulse with sticky err_code (01 chk, 10 len, 11 timeout).
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 480
) (
  input  logic       tick,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       rx_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {HUNT, LEN, PAY, CHK, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            rx_done_q;
  logic            rx_en_q, rx_en_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pkt_err_q, pkt_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            wr_en;
  logic [7:0]      mem_q [MAX_LEN];

  // Rising edge of rx_done; a level held for several cycles yields one event.
  logic byte_ev;
  logic tmo_hit;
  logic idx_at_last;
  assign byte_ev     = rx_done & ~rx_done_q;
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));
  assign idx_at_last = (idx_q == len_q - 8'd1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    pkt_err_d  = 1'b0;
    err_code_d = err_code_q;
    wr_en      = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (byte_ev && rx_data == SOF) state_d = LEN;
      end
      LEN: begin
        if (byte_ev) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b10;
            state_d    = HUNT;
          end else begin
            len_d   = rx_data;
            sum_d   = rx_data;
            idx_d   = 8'd0;
            state_d = PAY;
          end
        end else if (tmo_hit) begin
          pkt_err_d  = 1'b1;
          err_code_d = 2'b11;
          state_d    = HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PAY: begin
        if (byte_ev) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data;
          if (idx_at_last) begin
            idx_d   = 8'd0;
            state_d = CHK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (tmo_hit) begin
          pkt_err_d  = 1'b1;
          err_code_d = 2'b11;
          state_d    = HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHK: begin
        if (byte_ev) begin
          if (rx_data == sum_q) begin
            idx_d   = 8'd0;
            state_d = DRAIN;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b01;
            state_d    = HUNT;
          end
        end else if (tmo_hit) begin
          pkt_err_d  = 1'b1;
          err_code_d = 2'b11;
          state_d    = HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        // Receiver is held, so any rx_done edge here is ignored.
        if (out_ready) begin
          if (idx_at_last) begin
            idx_d   = 8'd0;
            state_d = HUNT;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    // Registered so that rx_en stays low during reset and rises on the first edge after it.
    rx_en_d = (state_d != DRAIN);
  end

  always_ff @(posedge tick or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      rx_done_q  <= 1'b0;
      rx_en_q    <= 1'b0;
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      idx_q      <= 8'd0;
      tmo_q      <= '0;
      pkt_err_q  <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= rx_done;
      rx_en_q    <= rx_en_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      pkt_err_q  <= pkt_err_d;
      err_code_q <= err_code_d;
    end
  end

  // Payload buffer carries no reset; it is only read after being written.
  always_ff @(posedge tick) begin
    if (wr_en) mem_q[idx_q[IW-1:0]] <= rx_data;
  end

  assign rx_en     = rx_en_q;
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? mem_q[idx_q[IW-1:0]] : 8'h00;
  assign out_last  = out_valid & idx_at_last;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Purpose: directed bench for uart_rx_pkt_ctrl with payload and error scoreboards.
// Latency: checks out_valid rises the cycle after the CHK byte event.
// Backpressure: toggles out_ready and checks out_data/out_valid hold while not accepted.
module tb_uart_rx_pkt_ctrl;

  logic       tick;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       pkt_err;
  logic [1:0] err_code;

  uart_rx_pkt_ctrl dut (
    .tick      (tick),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_en     (rx_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pkt_err   (pkt_err),
    .err_code  (err_code)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] err_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       bp_mode = 1'b0;
  logic [7:0] pay [16];

  initial begin
    tick = 1'b0;
    forever #5 tick = ~tick;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge tick);
      #2;
      out_ready = bp_mode ? ~out_ready : 1'b1;
    end
  end

  // Output monitor: pops expected payload bytes and error codes as the DUT produces them.
  logic       prev_hold = 1'b0;
  logic       prev_xfer_more = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge tick) begin
    if (!reset) begin
      prev_hold      = 1'b0;
      prev_xfer_more = 1'b0;
    end else begin
      if (prev_hold || prev_xfer_more) begin
        checks++;
        assert (out_valid === 1'b1) else begin
          errors++;
          $error("FAIL valid_hold: out_valid=%b required 1", out_valid);
        end
      end
      if (prev_hold) begin
        checks++;
        assert (out_data === prev_data) else begin
          errors++;
          $error("FAIL data_hold: out_data=%h required %h", out_data, prev_data);
        end
      end
      if (out_valid) begin
        checks++;
        assert (rx_en === 1'b0) else begin
          errors++;
          $error("FAIL rx_en_drain: rx_en=%b required 0", rx_en);
        end
      end
      prev_xfer_more = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_out: out_data=%h with no byte expected", out_data);
        end
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          assert ({out_data, out_last} === {e.d, e.l}) else begin
            errors++;
            $error("FAIL payload: data/last=%h/%b required %h/%b", out_data, out_last, e.d, e.l);
          end
        end
        prev_xfer_more = !out_last;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (pkt_err) begin
        checks++;
        assert (err_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_err: pkt_err=1 err_code=%b with none expected", err_code);
        end
        if (err_q.size() > 0) begin
          logic [1:0] c;
          c = err_q.pop_front();
          checks++;
          assert (err_code === c) else begin
            errors++;
            $error("FAIL err_code: err_code=%b required %b", err_code, c);
          end
        end
      end
    end
  end

  // One UART byte: rx_done held 3 cycles then low 4; optionally checks release latency.
  task automatic send_byte(input logic [7:0] b, input logic lat);
    @(posedge tick);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    if (lat) begin
      @(negedge tick);
      checks++;
      assert (out_valid === 1'b0) else begin
        errors++;
        $error("FAIL latency_early: out_valid=%b required 0", out_valid);
      end
      @(posedge tick);
      #1;
      checks++;
      assert (out_valid === 1'b1) else begin
        errors++;
        $error("FAIL latency: out_valid=%b required 1", out_valid);
      end
      @(posedge tick);
      #1;
    end else begin
      repeat (2) @(posedge tick);
      #1;
    end
    rx_done = 1'b0;
    repeat (4) @(posedge tick);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge tick);
      #1;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: %0d bytes still pending, required 0", tag, exp_q.size());
    end
  endtask

  task automatic wait_err(input int limit, input string tag);
    for (int i = 0; i < limit && err_q.size() != 0; i++) begin
      @(posedge tick);
      #1;
    end
    checks++;
    assert (err_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: %0d errors still pending, required 0", tag, err_q.size());
    end
  endtask

  // Good frame from pay[0..n-1] with the given checksum byte.
  task automatic good_frame(input int n, input logic [7:0] chk, input string tag);
    for (int i = 0; i < n; i++) exp_q.push_back('{d: pay[i], l: (i == n - 1)});
    send_byte(8'hA5, 1'b0);
    send_byte(8'(n), 1'b0);
    for (int i = 0; i < n; i++) send_byte(pay[i], 1'b0);
    send_byte(chk, 1'b1);
    wait_drain(tag);
    repeat (2) @(posedge tick);
    #1;
    checks++;
    assert (rx_en === 1'b1) else begin
      errors++;
      $error("FAIL %s_rx_en_after: rx_en=%b required 1", tag, rx_en);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({rx_en, out_valid, out_last, out_data, pkt_err, err_code} === 14'h0) else begin
      errors++;
      $error("FAIL %s: en/vld/last/data/err/code=%b/%b/%b/%h/%b/%b required all 0",
             tag, rx_en, out_valid, out_last, out_data, pkt_err, err_code);
    end
  endtask

  initial begin
    reset   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge tick);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    assert (rx_en === 1'b0) else begin
      errors++;
      $error("FAIL rx_en_release: rx_en=%b required 0", rx_en);
    end
    @(posedge tick);
    #1;
    checks++;
    assert (rx_en === 1'b1) else begin
      errors++;
      $error("FAIL rx_en_first_edge: rx_en=%b required 1", rx_en);
    end

    // Good frame, consumer always ready.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    good_frame(3, 8'h69, "good_frame");

    // Bad checksum.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    err_q.push_back(2'b01);
    send_byte(8'h00, 1'b0);
    wait_err(20, "bad_chk");
    repeat (5) @(posedge tick);
    #1;
    checks++;
    assert (err_code === 2'b01) else begin
      errors++;
      $error("FAIL err_code_held: err_code=%b required 01", err_code);
    end

    // Bad lengths: zero and above MAX_LEN.
    send_byte(8'hA5, 1'b0);
    err_q.push_back(2'b10);
    send_byte(8'h00, 1'b0);
    wait_err(20, "bad_len0");
    send_byte(8'hA5, 1'b0);
    err_q.push_back(2'b10);
    send_byte(8'h11, 1'b0);
    wait_err(20, "bad_len17");

    // Timeout after a partial payload.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    err_q.push_back(2'b11);
    send_byte(8'h01, 1'b0);
    repeat (400) @(posedge tick);
    #1;
    checks++;
    assert (err_q.size() == 1) else begin
      errors++;
      $error("FAIL timeout_early: pending=%0d required 1", err_q.size());
    end
    wait_err(200, "timeout");
    pay[0] = 8'h5A;
    good_frame(1, 8'h5B, "after_timeout");

    // Backpressure with checksum wrap.
    bp_mode = 1'b1;
    pay[0] = 8'hFF; pay[1] = 8'h02;
    good_frame(2, 8'h03, "backpressure");
    bp_mode = 1'b0;

    // Noise before SOF is ignored.
    send_byte(8'h00, 1'b0);
    send_byte(8'h37, 1'b0);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    good_frame(4, 8'h0E, "noise");

    // Reset mid-payload: immediate return to reset values, no error pulse.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_pay");
    repeat (3) @(posedge tick);
    #1;
    reset = 1'b1;
    @(posedge tick);
    #1;
    checks++;
    assert (rx_en === 1'b1) else begin
      errors++;
      $error("FAIL rx_en_after_reset: rx_en=%b required 1", rx_en);
    end
    repeat (20) @(posedge tick);
    #1;
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    good_frame(2, 8'h01, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 Parameter SOF, default 8'hA5, start-of-frame byte value.
REQ-002 Parameter MAX_LEN, default 16, maximum payload length in bytes, range 1..255.
REQ-003 Parameter TIMEOUT, default 480, inter-byte timeout in tick cycles (3 byte times at 16x oversampling).
REQ-004 tick  in  1  single clock shared with uartRX; all flops on its rising edge.
REQ-005 reset  in  1  asynchronous active-low reset; 0 = reset asserted.
REQ-006 rx_data  in  8  received byte from uartRX.
REQ-007 rx_done  in  1  uartRX byte-complete flag; may be held high for several cycles.
REQ-008 rx_en  out  1  drives uartRX reset input; 1 = receiver running, 0 = receiver held in reset.
REQ-009 out_data  out  8  payload byte to consumer.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  consumer accepts byte.
REQ-012 out_last  out  1  final payload byte of the packet, qualified by out_valid.
REQ-013 pkt_err  out  1  one-cycle pulse on a discarded packet.
REQ-014 err_code  out  2  cause of the last error: 01 checksum, 10 length, 11 timeout; held until the next error.

Function
REQ-015 Frame format: SOF, LEN, LEN payload bytes, CHK. CHK = (LEN + sum of payload bytes) mod 256.
REQ-016 Byte event: first cycle with rx_done=1 after a cycle with rx_done=0, using a registered edge detect; exactly one event per byte.
REQ-017 States: HUNT, LEN, PAY, CHK, DRAIN.
REQ-018 HUNT: rx_en=1; on a byte event equal to SOF, go to LEN; any other byte is dropped silently.
REQ-019 LEN: on a byte event with value 0 or greater than MAX_LEN, pulse pkt_err, set err_code=10, go to HUNT; otherwise store the length, initialise the running sum to LEN, go to PAY.
REQ-020 PAY: write each byte to a MAX_LEN x 8 buffer at write index 0..LEN-1 and add it to the running sum (8-bit wrap); after the LEN-th byte, go to CHK.
REQ-021 CHK: on a byte event, if the byte equals the running sum, go to DRAIN; otherwise pulse pkt_err, set err_code=01, go to HUNT.
REQ-022 DRAIN: rx_en=0; present the buffer in order. out_valid=1; a byte transfers in a cycle with out_valid and out_ready both 1. out_last=1 on index LEN-1. After the last transfer, go to HUNT with rx_en=1 in the following cycle.
REQ-023 out_data and out_valid stay stable while out_ready=0; out_valid is 1 only in DRAIN.
REQ-024 Timeout: in LEN, PAY and CHK, a counter counts cycles since the last byte event. When the count reaches TIMEOUT, pulse pkt_err, set err_code=11, go to HUNT. The counter clears on every byte event and on every state entry.
REQ-025 A byte event and a timeout in the same cycle: the byte event wins.
REQ-026 rx_done edges during DRAIN are ignored, because the receiver is held.
REQ-027 A rejected packet never produces out_valid; a good packet is released only after CHK passes.
REQ-028 Latency: out_valid rises in the cycle after the CHK byte event.

Reset
REQ-029 While reset=0 (asynchronously): state=HUNT, rx_en=0, out_valid=0, out_last=0, out_data=0, pkt_err=0, err_code=00, counters and indices 0, edge-detect register 0.
REQ-030 rx_en rises to 1 on the first tick edge after reset deasserts.
REQ-031 Reset in any state, including mid-DRAIN, discards the packet and emits no pkt_err.
REQ-032 Buffer contents need not be reset.

Verification
REQ-033 Good frame: A5,03,11,22,33,69 with out_ready=1 -> out_data 11,22,33 on consecutive cycles; out_last on 33; pkt_err never 1.
REQ-034 Bad checksum: A5,02,10,20,00 -> one pkt_err pulse, err_code=01, out_valid stays 0, state returns to HUNT.
REQ-035 Bad length: A5,00, then A5,11 (17 > MAX_LEN) -> two pkt_err pulses, err_code=10 each time.
REQ-036 Timeout: A5,04,01, then idle for 480 ticks -> pkt_err with err_code=11; a following good frame is accepted normally.
REQ-037 Backpressure: good frame A5,02,FF,02,03 with out_ready toggling 0/1 -> out_data FF then 02, each held until accepted; rx_en=0 throughout DRAIN; sum wraps correctly.
REQ-038 Noise and reset: bytes 00,37 before A5 are ignored; reset=0 asserted mid-PAY -> all outputs return to reset values immediately and no pkt_err is emitted.
